// File: rtl/drum_compressor_scheduler.sv
// Purpose : round-robin arbiter sharing one compression level detector among NUM_CH drum pads.
// Latency : request seen in IDLE at t -> det_start t+1 -> ch_ack t+5 (timeout: ch_ack t+2+TIMEOUT).
// Backpressure: one transaction in flight; other requesters wait, held ch_req is re-arbitrated after ack.
// Ports   : clock/reset (async active-low); ch_req/ch_level/ch_soft_limiter in, ch_ack/ch_gain/ch_err out;
//           det_start/det_input_level/det_soft_limiter/det_reset out, det_output_gain/det_done in;
//           busy, err_count (saturating timeout count).
module drum_compressor_scheduler #(
   parameter int NUM_CH  = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       ch_req,
   input  logic [9*NUM_CH-1:0]     ch_level,
   input  logic [NUM_CH-1:0]       ch_soft_limiter,
   output logic [NUM_CH-1:0]       ch_ack,
   output logic signed [8:0]       ch_gain,
   output logic                    ch_err,
   output logic                    det_start,
   output logic signed [8:0]       det_input_level,
   output logic                    det_soft_limiter,
   output logic                    det_reset,
   input  logic signed [8:0]       det_output_gain,
   input  logic                    det_done,
   output logic                    busy,
   output logic [7:0]              err_count
);

   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESPOND, RECOVER} state_t;

   state_t          state;
   logic [IW-1:0]   grant;
   logic [IW-1:0]   last_grant;
   logic [TW-1:0]   timer;

   logic            sel_vld;
   logic [IW-1:0]   sel_idx;

   // Search upward from the channel after the last one served, wrapping,
   // so every persistent requester is reached within NUM_CH grants.
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         if (!sel_vld && ch_req[(int'(last_grant) + k) % NUM_CH]) begin
            sel_vld = 1'b1;
            sel_idx = IW'((int'(last_grant) + k) % NUM_CH);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         grant            <= '0;
         last_grant       <= IW'(NUM_CH - 1);
         timer            <= '0;
         ch_ack           <= '0;
         ch_gain          <= '0;
         ch_err           <= 1'b0;
         det_start        <= 1'b0;
         det_input_level  <= '0;
         det_soft_limiter <= 1'b0;
         // Held high through reset so the detector's synchronous state is
         // cleared on the first edge after release.
         det_reset        <= 1'b1;
         busy             <= 1'b0;
         err_count        <= '0;
      end else begin
         // Pulse outputs default low; the transitions below raise them for one cycle.
         det_start <= 1'b0;
         det_reset <= 1'b0;
         ch_ack    <= '0;
         ch_err    <= 1'b0;
         case (state)
            IDLE: begin
               if (sel_vld) begin
                  grant            <= sel_idx;
                  det_input_level  <= ch_level[9*int'(sel_idx) +: 9];
                  det_soft_limiter <= ch_soft_limiter[sel_idx];
                  det_start        <= 1'b1;
                  busy             <= 1'b1;
                  state            <= ISSUE;
               end else begin
                  busy <= 1'b0;
               end
            end
            ISSUE: begin
               timer <= '0;
               state <= WAIT;
            end
            WAIT: begin
               // done is tested first so it wins over a coincident timeout.
               if (det_done) begin
                  ch_gain <= det_output_gain;
                  ch_ack  <= NUM_CH'(1) << grant;
                  state   <= RESPOND;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  ch_gain   <= '0;
                  ch_err    <= 1'b1;
                  ch_ack    <= NUM_CH'(1) << grant;
                  det_reset <= 1'b1;
                  if (err_count != 8'hFF) begin
                     err_count <= err_count + 8'd1;
                  end
                  state     <= RECOVER;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            RESPOND, RECOVER: begin
               last_grant <= grant;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_drum_compressor_scheduler.sv
// Purpose : directed bench for drum_compressor_scheduler with a small detector model.
// Latency : detector model answers done 3 cycles after the det_start cycle.
// Backpressure: requesters hold ch_req until their ack, then drop it.
module tb_drum_compressor_scheduler;

   localparam int NUM_CH  = 4;
   localparam int TIMEOUT = 16;

   logic                    clock;
   logic                    reset;
   logic [NUM_CH-1:0]       ch_req;
   logic [9*NUM_CH-1:0]     ch_level;
   logic [NUM_CH-1:0]       ch_soft_limiter;
   logic [NUM_CH-1:0]       ch_ack;
   logic signed [8:0]       ch_gain;
   logic                    ch_err;
   logic                    det_start;
   logic signed [8:0]       det_input_level;
   logic                    det_soft_limiter;
   logic                    det_reset;
   logic signed [8:0]       det_output_gain;
   logic                    det_done;
   logic                    busy;
   logic [7:0]              err_count;

   int n_cmp = 0;
   int n_bad = 0;

   drum_compressor_scheduler #(.NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)) dut (
      .clock            (clock),
      .reset            (reset),
      .ch_req           (ch_req),
      .ch_level         (ch_level),
      .ch_soft_limiter  (ch_soft_limiter),
      .ch_ack           (ch_ack),
      .ch_gain          (ch_gain),
      .ch_err           (ch_err),
      .det_start        (det_start),
      .det_input_level  (det_input_level),
      .det_soft_limiter (det_soft_limiter),
      .det_reset        (det_reset),
      .det_output_gain  (det_output_gain),
      .det_done         (det_done),
      .busy             (busy),
      .err_count        (err_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Detector model: done three cycles after the det_start cycle when enabled.
   // In follow mode the gain is the negated level captured at start.
   logic [2:0]        sr;
   logic signed [8:0] lvl_cap;
   logic              model_en;
   logic              follow;
   logic              inj_done;
   logic signed [8:0] model_gain;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         sr      <= '0;
         lvl_cap <= '0;
      end else begin
         sr <= {sr[1:0], det_start & model_en};
         if (det_start) lvl_cap <= det_input_level;
      end
   end

   assign det_done        = sr[2] | inj_done;
   assign det_output_gain = follow ? -lvl_cap : model_gain;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_level(input int ch, input int val);
      ch_level[9*ch +: 9] = 9'(val);
   endtask

   // Advance one negedge at a time until an ack shows; n is cycles taken.
   task automatic wait_ack(input int max, output int n);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (ch_ack == '0 && n < max);
      check("ack_seen", int'(ch_ack != '0), 1);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   int n;

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      ch_req = '0;
      ch_level = '0;
      ch_soft_limiter = '0;
      model_en = 1'b1;
      follow = 1'b0;
      inj_done = 1'b0;
      model_gain = -9'sd7;

      // Reset values
      @(negedge clock);
      check("rst_busy", int'(busy), 0);
      check("rst_ack", int'(ch_ack), 0);
      check("rst_gain", int'(ch_gain), 0);
      check("rst_err", int'(ch_err), 0);
      check("rst_start", int'(det_start), 0);
      check("rst_level", int'(det_input_level), 0);
      check("rst_soft", int'(det_soft_limiter), 0);
      check("rst_detrst", int'(det_reset), 1);
      check("rst_errcnt", int'(err_count), 0);
      @(negedge clock);
      reset = 1'b1;
      #1 check("detrst_after_release", int'(det_reset), 1);
      @(negedge clock);
      check("detrst_one_cycle", int'(det_reset), 0);

      // Single nominal transaction on channel 0
      set_level(0, 100);
      ch_req = 4'b0001;
      @(negedge clock);
      check("t1_start", int'(det_start), 1);
      check("t1_level", int'(det_input_level), 100);
      check("t1_busy", int'(busy), 1);
      @(negedge clock);
      check("t1_start_pulse", int'(det_start), 0);
      @(negedge clock);
      @(negedge clock);
      check("t1_no_early_ack", int'(ch_ack), 0);
      @(negedge clock);
      check("t1_ack", int'(ch_ack), 1);
      check("t1_gain", int'(ch_gain), -7);
      check("t1_err", int'(ch_err), 0);
      ch_req = '0;
      @(negedge clock);
      check("t1_ack_pulse", int'(ch_ack), 0);
      check("t1_idle", int'(busy), 0);

      // Round robin with all four held, after reset so channel 0 goes first
      do_reset();
      follow = 1'b1;
      for (int i = 0; i < NUM_CH; i++) set_level(i, 10 * (i + 1));
      ch_req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_ack(20, n);
         check($sformatf("rr%0d_spacing", k), n, (k == 0) ? 5 : 6);
         check($sformatf("rr%0d_ack", k), int'(ch_ack), 1 << (k % NUM_CH));
         check($sformatf("rr%0d_gain", k), int'(ch_gain), -10 * ((k % NUM_CH) + 1));
      end
      ch_req = '0;
      follow = 1'b0;
      @(negedge clock);
      @(negedge clock);

      // Timeout path on channel 2
      model_en = 1'b0;
      ch_req = 4'b0100;
      wait_ack(40, n);
      check("to_latency", n, 2 + TIMEOUT);
      check("to_ack", int'(ch_ack), 4);
      check("to_err", int'(ch_err), 1);
      check("to_gain", int'(ch_gain), 0);
      check("to_detrst", int'(det_reset), 1);
      check("to_errcnt", int'(err_count), 1);
      ch_req = '0;
      @(negedge clock);
      check("to_detrst_pulse", int'(det_reset), 0);
      check("to_ack_pulse", int'(ch_ack), 0);

      // Saturation of the timeout counter
      for (int i = 0; i < 299; i++) begin
         ch_req = 4'b0100;
         wait_ack(40, n);
         if (i == 252) check("errcnt_254", int'(err_count), 254);
         ch_req = '0;
         @(negedge clock);
      end
      check("errcnt_sat", int'(err_count), 255);

      // Stray done in IDLE is ignored
      inj_done = 1'b1;
      @(negedge clock);
      inj_done = 1'b0;
      check("stray_busy", int'(busy), 0);
      check("stray_ack", int'(ch_ack), 0);
      check("stray_start", int'(det_start), 0);

      // Done on the last WAIT cycle wins over timeout; last_grant=2 so ch1 after 3,0
      model_gain = 9'sd55;
      ch_req = 4'b0010;
      for (int i = 0; i < TIMEOUT + 1; i++) @(negedge clock);
      check("late_no_ack_yet", int'(ch_ack), 0);
      inj_done = 1'b1;
      @(negedge clock);
      inj_done = 1'b0;
      check("late_ack", int'(ch_ack), 2);
      check("late_gain", int'(ch_gain), 55);
      check("late_err", int'(ch_err), 0);
      check("late_errcnt", int'(err_count), 255);
      ch_req = '0;
      @(negedge clock);

      // Reset during WAIT; ch3 granted first (last_grant=1), then re-arbitrated from ch0 order
      model_en = 1'b1;
      model_gain = -9'sd20;
      set_level(1, 33);
      set_level(3, 44);
      ch_req = 4'b1010;
      @(negedge clock);
      check("mid_level_ch3", int'(det_input_level), 44);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_ack", int'(ch_ack), 0);
      check("mid_rst_detrst", int'(det_reset), 1);
      check("mid_rst_errcnt", int'(err_count), 0);
      check("mid_rst_level", int'(det_input_level), 0);
      @(negedge clock);
      check("mid_rst_no_ack", int'(ch_ack), 0);
      @(negedge clock);
      reset = 1'b1;
      #1 check("mid_detrst_release", int'(det_reset), 1);
      @(negedge clock);
      check("mid_detrst_low", int'(det_reset), 0);
      check("mid_regrant_start", int'(det_start), 1);
      check("mid_regrant_level", int'(det_input_level), 33);
      wait_ack(20, n);
      check("mid_regrant_lat", n, 4);
      check("mid_regrant_ack", int'(ch_ack), 2);
      check("mid_regrant_gain", int'(ch_gain), -20);
      ch_req = '0;
      @(negedge clock);

      // Soft limiter and level latched at grant only
      follow = 1'b1;
      set_level(2, 77);
      ch_soft_limiter = 4'b0100;
      ch_req = 4'b0100;
      @(negedge clock);
      check("sl_start", int'(det_start), 1);
      check("sl_soft", int'(det_soft_limiter), 1);
      check("sl_level", int'(det_input_level), 77);
      set_level(2, -5);
      ch_soft_limiter = '0;
      @(negedge clock);
      check("sl_level_held", int'(det_input_level), 77);
      check("sl_soft_held", int'(det_soft_limiter), 1);
      wait_ack(20, n);
      check("sl_ack", int'(ch_ack), 4);
      check("sl_gain", int'(ch_gain), -77);
      ch_req = '0;
      @(negedge clock);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
